instr_fetch_unit: RTL and testbench

//  Fetch stage ahead of instruction_decoder. Owns the program counter and drives ROM address/oe.

---
 rtl/proc_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 78 +++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared fetch-stage definitions: default widths, halt opcode and fetch state encoding.
package proc_pkg;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_INSTR_W = 16;
  localparam logic [DEF_INSTR_W-1:0] DEF_HALT_CODE = 16'hFFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, word}; pointers carry an extra wrap bit for full/empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 21
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0][W-1:0] mem;
  logic do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head    = mem[rd_ptr[PW-1:0]];
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM, queues fetched words and hands them to decode.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int                 ADDR_W    = DEF_ADDR_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 DEPTH     = 2,
  parameter int                 PROG_LEN  = 16,
  parameter logic [INSTR_W-1:0] HALT_CODE = DEF_HALT_CODE
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  output logic               rom_oe,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_addr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted,
  output logic               addr_err
);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] PC_ONE   = 1;
  localparam logic [ADDR_W:0]   PROG_END = (ADDR_W + 1)'(PROG_LEN);

  logic [ADDR_W-1:0] pc;
  fetch_state_e      state;
  logic              full, empty, pop, issue, bad_jmp;

  assign pop     = instr_valid && instr_ready;
  // A jump owns the cycle: no fetch issues alongside it.
  assign issue   = rstn && (state == RUN) && en && !jmp_valid && (!full || pop);
  assign bad_jmp = ({1'b0, jmp_addr} >= PROG_END);

  assign rom_oe      = issue;
  assign rom_addr    = pc;
  assign instr_valid = !empty;
  assign halted      = (state == HALT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc       <= '0;
      state    <= RUN;
      addr_err <= 1'b0;
    end else if (jmp_valid) begin
      state <= RUN;
      if (bad_jmp) begin
        pc       <= '0;
        addr_err <= 1'b1;
      end else begin
        pc <= jmp_addr;
      end
    end else if (issue) begin
      pc <= (pc == LAST_PC) ? '0 : pc + PC_ONE;
      // The halt word itself is still queued; fetching stops after it.
      if (rom_data == HALT_CODE) state <= HALT;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (issue),
    .pop   (pop && !jmp_valid),
    .flush (jmp_valid),
    .din   ({pc, rom_data}),
    .full  (full),
    .empty (empty),
    .head  ({instr_pc, instr_data})
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an expected-word scoreboard checked at each accepted handshake.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        rom_oe;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        jmp_valid = 1'b0;
  logic [4:0]  jmp_addr = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_data;
  logic [4:0]  instr_pc;
  logic        halted;
  logic        addr_err;

  logic [15:0] rom [32];
  assign rom_data = rom[rom_addr];

  instr_fetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .rom_oe      (rom_oe),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .halted      (halted),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int passed = 0;
  int total  = 0;
  int pops   = 0;
  int cyc    = 0;
  int start;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Accepted words are compared in order against what the bench expects delivered.
  always @(negedge clk) begin
    if (rstn && instr_valid && instr_ready && !jmp_valid) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("head_pc", instr_pc, mon_e.pc);
        chk("head_data", instr_data, mon_e.data);
      end
      pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push_exp(input int pc, input logic [15:0] data);
    exp_t e;
    e.pc   = 5'(pc);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_pops(input int n, input int bound, input string tag);
    for (int i = 0; i < bound && pops < n; i++) tick();
    chk({tag, "_pops"}, pops, n);
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    en          = 1'b0;
    instr_ready = 1'b0;
    jmp_valid   = 1'b0;
    #1;
    tick();
    tick();
    sb.delete();
    pops = 0;
    for (int i = 0; i < 32; i++) rom[i] = 16'(16'h0100 + i);
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'(16'h0100 + i);
    tick();
    tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_oe", rom_oe, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_data", instr_data, 0);
    rstn = 1'b1;

    // 1: free-running stream with PC wrap 15 -> 0
    for (int k = 0; k < 18; k++) push_exp(k % 16, 16'(16'h0100 + (k % 16)));
    en = 1'b1;
    instr_ready = 1'b1;
    start = cyc;
    wait_pops(18, 40, "t1");
    chk("t1_elapsed", cyc - start, 19);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: backpressure fills queue, then drains without gap or duplicate
    do_reset();
    for (int k = 0; k < 5; k++) push_exp(k, 16'(16'h0100 + k));
    en = 1'b1;
    settle();
    chk("t2_first_oe", rom_oe, 1);
    chk("t2_first_addr", rom_addr, 0);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t2_full_oe", rom_oe, 0);
      chk("t2_full_addr", rom_addr, 2);
      chk("t2_head_pc", instr_pc, 0);
      chk("t2_head_data", instr_data, 16'h0100);
      chk("t2_head_valid", instr_valid, 1);
      tick();
    end
    instr_ready = 1'b1;
    settle();
    chk("t2_fullpop_oe", rom_oe, 1);
    start = cyc;
    wait_pops(5, 20, "t2");
    instr_ready = 1'b0;
    chk("t2_elapsed", cyc - start, 5);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: halt opcode stops fetching; jump restarts
    do_reset();
    rom[3] = 16'hFFFF;
    push_exp(0, 16'h0100);
    push_exp(1, 16'h0101);
    push_exp(2, 16'h0102);
    push_exp(3, 16'hFFFF);
    en = 1'b1;
    instr_ready = 1'b1;
    wait_pops(4, 20, "t3a");
    settle();
    chk("t3_halted", halted, 1);
    chk("t3_halt_oe", rom_oe, 0);
    chk("t3_halt_valid", instr_valid, 0);
    chk("t3_halt_addr", rom_addr, 4);
    tick();
    chk("t3_still_empty", instr_valid, 0);
    jmp_valid = 1'b1;
    jmp_addr  = 5'd8;
    push_exp(8, 16'h0108);
    push_exp(9, 16'h0109);
    settle();
    chk("t3_jmp_oe", rom_oe, 0);
    chk("t3_jmp_halted", halted, 1);
    tick();
    jmp_valid = 1'b0;
    settle();
    chk("t3_resume_halted", halted, 0);
    chk("t3_resume_oe", rom_oe, 1);
    chk("t3_resume_addr", rom_addr, 8);
    wait_pops(6, 20, "t3b");
    instr_ready = 1'b0;
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_err", addr_err, 0);

    // 4: jump flushes a full queue holding pc1, pc2
    do_reset();
    push_exp(0, 16'h0100);
    en = 1'b1;
    tick();
    tick();
    instr_ready = 1'b1;
    tick();
    jmp_valid = 1'b1;
    jmp_addr  = 5'd5;
    push_exp(5, 16'h0105);
    settle();
    chk("t4_pre_pc", instr_pc, 1);
    chk("t4_pre_valid", instr_valid, 1);
    chk("t4_jmp_oe", rom_oe, 0);
    tick();
    jmp_valid = 1'b0;
    settle();
    chk("t4_flush_valid", instr_valid, 0);
    chk("t4_new_addr", rom_addr, 5);
    chk("t4_new_oe", rom_oe, 1);
    tick();
    settle();
    chk("t4_next_valid", instr_valid, 1);
    chk("t4_next_pc", instr_pc, 5);
    wait_pops(2, 10, "t4");
    instr_ready = 1'b0;
    chk("t4_sb_empty", sb.size(), 0);

    // 5: out-of-range jump, sticky error, then reset mid-stream
    do_reset();
    en = 1'b1;
    instr_ready = 1'b1;
    tick();
    jmp_valid = 1'b1;
    jmp_addr  = 5'd20;
    for (int k = 0; k < 3; k++) push_exp(k, 16'(16'h0100 + k));
    settle();
    chk("t5_jmp_oe", rom_oe, 0);
    tick();
    jmp_valid = 1'b0;
    jmp_addr  = 5'd0;
    settle();
    chk("t5_err_set", addr_err, 1);
    chk("t5_addr", rom_addr, 0);
    chk("t5_flush_valid", instr_valid, 0);
    wait_pops(3, 20, "t5");
    chk("t5_err_sticky", addr_err, 1);
    chk("t5_sb_empty", sb.size(), 0);
    rstn = 1'b0;
    #1;
    chk("t5_rst_valid", instr_valid, 0);
    chk("t5_rst_addr", rom_addr, 0);
    chk("t5_rst_err", addr_err, 0);
    chk("t5_rst_oe", rom_oe, 0);
    chk("t5_rst_halted", halted, 0);
    tick();
    rstn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
